// File: rtl/timer_sched.sv
// Round-robin interval timer: grants one requester at a time, loads its len, counts down to zero, pulses done.
// Define TIMER_SCHED_ABORT_EN to add the abort input and aborted pulse output.
module timer_sched #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         cur_cnt
`ifdef TIMER_SCHED_ABORT_EN
  ,
  input  logic                     abort,
  output logic                     aborted
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;

  logic [CNT_W-1:0]   len_arr [NUM_REQ];
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   sel;
  logic               found;

`ifdef TIMER_SCHED_ABORT_EN
  logic aborted_q, aborted_d;
`endif

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      len_arr[i] = len[i*CNT_W +: CNT_W];
    end
  end

  // Rotating priority search: first set req bit at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
`ifdef TIMER_SCHED_ABORT_EN
    aborted_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          gidx_d       = sel;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = len_arr[gidx_q];
        state_d = COUNT;
      end
      COUNT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          done_d[gidx_q] = 1'b1;
          state_d        = DONE;
        end
      end
      DONE: begin
        grant_d = '0;
        ptr_d   = wrap_inc(gidx_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef TIMER_SCHED_ABORT_EN
    // Abort overrides the normal LOAD/COUNT step, including a pending done.
    if (abort && (state_q == LOAD || state_q == COUNT)) begin
      state_d   = IDLE;
      grant_d   = '0;
      done_d    = '0;
      cnt_d     = cnt_q;
      ptr_d     = wrap_inc(gidx_q);
      aborted_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
    end
  end

`ifdef TIMER_SCHED_ABORT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end

  assign aborted = aborted_q;
`endif

  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);
  assign cur_cnt = cnt_q;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: single, zero-length, round-robin, max-length, mid-count reset, optional abort.
module tb_timer_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [39:0] len;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [9:0]  cur_cnt;
`ifdef TIMER_SCHED_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  int checks;
  int errors;

  timer_sched #(.NUM_REQ(4), .CNT_W(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .len     (len),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .cur_cnt (cur_cnt)
`ifdef TIMER_SCHED_ABORT_EN
    ,
    .abort   (abort),
    .aborted (aborted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a grant, then follows it to the IDLE cycle after it.
  task automatic run_op(input logic [3:0] exp_g, input int exp_cyc, input logic [3:0] clr,
                        input string tag, output int gap, output logic [9:0] mx);
    int n;
    int dn;
    gap = 0;
    while (grant == 4'b0 && gap < 50) begin
      tick();
      gap++;
    end
    chk({tag, "_grant"}, grant, exp_g);
    n  = 0;
    dn = 0;
    mx = '0;
    while (grant != 4'b0 && n < 1100) begin
      if (done != 4'b0) begin
        dn++;
        chk({tag, "_done_idx"}, done, exp_g);
        req = req & ~clr;
      end
      if (cur_cnt > mx) mx = cur_cnt;
      n++;
      tick();
    end
    chk({tag, "_cycles"}, n, exp_cyc);
    chk({tag, "_done_cnt"}, dn, 1);
    chk({tag, "_idle_done"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int          gap;
    int          n;
    int          dn;
    logic [9:0]  mx;
    logic [3:0]  rr_exp [5];

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    req    = 4'b0;
    len    = '0;
`ifdef TIMER_SCHED_ABORT_EN
    abort  = 1'b0;
`endif
    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cur_cnt, 0);
    reset = 1'b0;
    tick();
    chk("idle_noreq_grant", grant, 0);
    chk("idle_noreq_busy", busy, 0);

    // Single request, len0=5: LOAD, count 5..0, DONE = 8 grant cycles.
    len[0 +: 10] = 10'd5;
    req = 4'b0001;
    tick();
    chk("t1_load_grant", grant, 4'b0001);
    chk("t1_load_busy", busy, 1);
    for (int i = 5; i >= 0; i--) begin
      tick();
      chk("t1_cnt", cur_cnt, i);
      chk("t1_cnt_grant", grant, 4'b0001);
      chk("t1_cnt_done", done, 0);
    end
    tick();
    chk("t1_done", done, 4'b0001);
    chk("t1_done_grant", grant, 4'b0001);
    req = 4'b0000;
    tick();
    chk("t1_end_grant", grant, 0);
    chk("t1_end_done", done, 0);
    chk("t1_end_busy", busy, 0);

    // Zero length on index 2 (ptr now 1): 3 grant cycles.
    len[20 +: 10] = 10'd0;
    req = 4'b0100;
    run_op(4'b0100, 3, 4'b0100, "t2", gap, mx);

    // Round-robin from ptr 0 with all len=1: 4 cycles each, one idle cycle between.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    len = {10'd1, 10'd1, 10'd1, 10'd1};
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_op(rr_exp[i], 4, (i == 4) ? 4'b1111 : 4'b0000, "t3_rr", gap, mx);
      chk("t3_rr_gap", gap, 1);
    end

    // Max length on index 1 (ptr now 1): 1026 grant cycles, counter starts at 1023.
    len[10 +: 10] = 10'd1023;
    req = 4'b0010;
    run_op(4'b0010, 1026, 4'b0010, "t4_max", gap, mx);
    chk("t4_max_cnt", mx, 1023);

    // Mid-count reset with len0=20 (ptr now 2, wraps to 0).
    len[0 +: 10]  = 10'd20;
    len[10 +: 10] = 10'd2;
    req = 4'b0001;
    n  = 0;
    dn = 0;
    while (!(grant == 4'b0001 && busy && cur_cnt == 10'd10) && n < 100) begin
      if (done != 4'b0) dn++;
      tick();
      n++;
    end
    chk("t5_reach10", cur_cnt, 10);
    reset = 1'b1;
    req = 4'b0010;
    #1;
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cnt", cur_cnt, 0);
    tick();
    if (done != 4'b0) dn++;
    reset = 1'b0;
    tick();
    chk("t5_no_done", dn, 0);
    chk("t5_resume_grant", grant, 4'b0010);
    run_op(4'b0010, 5, 4'b0010, "t5_next", gap, mx);

`ifdef TIMER_SCHED_ABORT_EN
    // Abort in IDLE is ignored; abort mid-count on index 3 advances ptr to 0.
    abort = 1'b1;
    tick();
    chk("t6_idle_aborted", aborted, 0);
    chk("t6_idle_busy", busy, 0);
    abort = 1'b0;
    len[30 +: 10] = 10'd50;
    req = 4'b1000;
    n  = 0;
    dn = 0;
    while (!(grant == 4'b1000 && busy && cur_cnt == 10'd30) && n < 100) begin
      if (done != 4'b0) dn++;
      tick();
      n++;
    end
    chk("t6_reach30", cur_cnt, 30);
    abort = 1'b1;
    tick();
    chk("t6_aborted", aborted, 1);
    chk("t6_abort_grant", grant, 0);
    chk("t6_abort_done", done, 0);
    chk("t6_no_done", dn, 0);
    abort = 1'b0;
    req = 4'b1001;
    tick();
    chk("t6_aborted_pulse", aborted, 0);
    chk("t6_next_grant", grant, 4'b0001);
    run_op(4'b0001, 23, 4'b1001, "t6_next", gap, mx);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
